// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares the RAM command-word port between an SPI slave and a local host.
// Define SPI_ARB_STATUS_EN to add the err_overflow / lock_timeouts status outputs.
module spi_ram_arbiter #(
  parameter int LOCK_TIMEOUT = 64,
  parameter int TMR_W = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  input  logic       spi_rx_valid,
  input  logic [9:0] spi_rx_data,
  output logic       spi_tx_valid,
  output logic [7:0] spi_tx_data,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic       host_rvalid,
  output logic [7:0] host_rdata,
  output logic       ram_rx_valid,
  output logic [9:0] ram_din,
  input  logic       ram_tx_valid,
  input  logic [7:0] ram_dout
`ifdef SPI_ARB_STATUS_EN
  ,
  output logic       err_overflow,
  output logic [7:0] lock_timeouts
`endif
);
  typedef enum logic [2:0] {IDLE, SPI_LOCK, SPI_RDW, H_ADDR, H_DATA, H_RDW} state_t;
  state_t state, fwd_next;
  logic skid_valid, h_we, fwd, pend, live_to_skid, timer_hit;
  logic [9:0] skid_data, word;
  logic [7:0] h_wdata;
  logic [TMR_W-1:0] timer;
  // SPI words are forwarded only in IDLE/SPI_LOCK; the skid entry is always older than a live word
  assign fwd = (state == IDLE) || (state == SPI_LOCK);
  assign pend = skid_valid || spi_rx_valid;
  assign word = skid_valid ? skid_data : spi_rx_data;
  assign live_to_skid = spi_rx_valid && (!fwd || skid_valid);
  assign timer_hit = timer == TMR_W'(LOCK_TIMEOUT);
  always_comb fwd_next = (word[9:8] == 2'b01) ? IDLE : (word[9:8] == 2'b11) ? SPI_RDW : SPI_LOCK;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      skid_valid <= 1'b0;
      skid_data <= '0;
      timer <= '0;
      h_we <= 1'b0;
      h_wdata <= '0;
      ram_rx_valid <= 1'b0;
      ram_din <= '0;
      host_gnt <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata <= '0;
      spi_tx_valid <= 1'b0;
      spi_tx_data <= '0;
    end else begin
      ram_rx_valid <= 1'b0;
      host_gnt <= 1'b0;
      host_rvalid <= 1'b0;
      spi_tx_valid <= 1'b0;
      if (live_to_skid && (fwd || !skid_valid)) begin
        skid_valid <= 1'b1;
        skid_data <= spi_rx_data;
      end else if (fwd && skid_valid) skid_valid <= 1'b0;
      if (fwd && pend) begin
        ram_rx_valid <= 1'b1;
        ram_din <= word;
        timer <= '0;
        state <= fwd_next;
      end else begin
        case (state)
          IDLE: if (host_req) begin
            ram_rx_valid <= 1'b1;
            ram_din <= {host_we ? 2'b00 : 2'b10, host_addr};
            host_gnt <= 1'b1;
            h_we <= host_we;
            h_wdata <= host_wdata;
            state <= H_ADDR;
          end
          SPI_LOCK: if (ss_n || timer_hit) state <= IDLE;
                    else timer <= timer + TMR_W'(1);
          H_ADDR: begin
            ram_rx_valid <= 1'b1;
            ram_din <= h_we ? {2'b01, h_wdata} : 10'h300;
            state <= H_DATA;
          end
          H_DATA: state <= h_we ? IDLE : H_RDW;
          SPI_RDW: if (ram_tx_valid) begin
            spi_tx_valid <= 1'b1;
            spi_tx_data <= ram_dout;
            state <= IDLE;
          end
          H_RDW: if (ram_tx_valid) begin
            host_rvalid <= 1'b1;
            host_rdata <= ram_dout;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef SPI_ARB_STATUS_EN
  logic overflow, tmo;
  assign overflow = spi_rx_valid && skid_valid && !fwd;
  assign tmo = (state == SPI_LOCK) && !pend && !ss_n && timer_hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
      lock_timeouts <= '0;
    end else begin
      if (overflow) err_overflow <= 1'b1;
      if (tmo && lock_timeouts != 8'hFF) lock_timeouts <= lock_timeouts + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: table vectors, directed corner sequences and randomized traffic
// against a behavioural memory model for spi_ram_arbiter.
module tb_spi_ram_arbiter;
  localparam int LOCK_TIMEOUT = 64;
  logic clk = 1'b0, rst, ss_n, spi_rx_valid, host_req, host_we, mem_clr;
  logic [9:0] spi_rx_data;
  logic [7:0] host_addr, host_wdata;
  logic spi_tx_valid, host_gnt, host_rvalid, ram_rx_valid, ram_tx_valid;
  logic [7:0] spi_tx_data, host_rdata, ram_dout;
  logic [9:0] ram_din;
`ifdef SPI_ARB_STATUS_EN
  logic err_overflow;
  logic [7:0] lock_timeouts;
`endif
  int total = 0, bad = 0;
  bit rand_on = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] ram_a;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];

  spi_ram_arbiter #(.LOCK_TIMEOUT(LOCK_TIMEOUT), .TMR_W(7)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n),
    .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data),
    .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout)
`ifdef SPI_ARB_STATUS_EN
    , .err_overflow(err_overflow), .lock_timeouts(lock_timeouts)
`endif
  );

  always #5 clk = ~clk;

  // RAM: latches an address on 00/10, writes on 01, answers 11 one cycle later
  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ram_a <= ram_din[7:0];
        2'b01: mem[ram_a] <= ram_din[7:0];
        default: begin
          ram_tx_valid <= 1'b1;
          ram_dout <= mem[ram_a];
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rand_on && spi_tx_valid) begin
      if (exp_q.size() > 0) chk("spi_rd", spi_tx_data, exp_q.pop_front());
      else chk("spi_rd_extra", spi_tx_valid, 0);
    end

  // Sends a word expected to be forwarded straight away; reads are answered two cycles later.
  task automatic spi_send(input logic [9:0] w, input logic [7:0] exp_rd);
    spi_rx_valid = 1'b1;
    spi_rx_data = w;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    chk("spi_fwd", {ram_rx_valid, ram_din}, {1'b1, w});
    if (w[9:8] == 2'b11) begin
      @(negedge clk);
      @(negedge clk);
      chk("spi_tx", {spi_tx_valid, host_rvalid, spi_tx_data}, {1'b1, 1'b0, exp_rd});
    end
  endtask

  task automatic spi_raw(input logic [9:0] w);
    spi_rx_valid = 1'b1;
    spi_rx_data = w;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    repeat ($urandom_range(9, 13)) @(negedge clk);
  endtask

  task automatic host_op(input bit we, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input int maxw, output int waited);
    host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = wd;
    waited = 0;
    while (waited < maxw) begin
      @(negedge clk);
      waited++;
      if (host_gnt) break;
    end
    host_req = 1'b0;
    chk("host_gnt", host_gnt, 1);
    if (host_gnt) begin
      chk("h_addr_word", {ram_rx_valid, ram_din}, {1'b1, we ? 2'b00 : 2'b10, a});
      @(negedge clk);
      chk("h_data_word", {ram_rx_valid, ram_din}, {1'b1, we ? {2'b01, wd} : 10'h300});
      if (!we) begin
        @(negedge clk);
        chk("h_rvalid_early", host_rvalid, 0);
        @(negedge clk);
        chk("host_rd", {host_rvalid, spi_tx_valid, host_rdata}, {1'b1, 1'b0, exp_rd});
      end
    end
  endtask

  typedef struct {
    bit host;
    bit we;
    logic [9:0] w;
    logic [7:0] wd;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [7:0] a, d;
    tbl[0]  = '{0, 0, 10'h055, 8'h00, 8'h00};
    tbl[1]  = '{0, 0, 10'h1A7, 8'h00, 8'h00};
    tbl[2]  = '{1, 0, 10'h055, 8'h00, 8'hA7};
    tbl[3]  = '{0, 0, 10'h255, 8'h00, 8'h00};
    tbl[4]  = '{0, 0, 10'h300, 8'h00, 8'hA7};
    tbl[5]  = '{1, 1, 10'h090, 8'h5A, 8'h00};
    tbl[6]  = '{0, 0, 10'h290, 8'h00, 8'h00};
    tbl[7]  = '{0, 0, 10'h300, 8'h00, 8'h5A};
    tbl[8]  = '{1, 0, 10'h090, 8'h00, 8'h5A};
    tbl[9]  = '{0, 0, 10'h0C3, 8'h00, 8'h00};
    tbl[10] = '{0, 0, 10'h1E1, 8'h00, 8'h00};
    tbl[11] = '{1, 0, 10'h0C3, 8'h00, 8'hE1};
    rst = 1'b1; mem_clr = 1'b1; ss_n = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {spi_tx_valid, spi_tx_data, host_gnt, host_rvalid, host_rdata, ram_rx_valid, ram_din}, 0);
`ifdef SPI_ARB_STATUS_EN
    chk("reset_status", {err_overflow, lock_timeouts}, 0);
`endif
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("post_reset_strobe", ram_rx_valid, 0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].host) begin
        host_op(tbl[i].we, tbl[i].w[7:0], tbl[i].wd, tbl[i].rd, 10, w);
        chk("host_gnt_lat", w, 1);
      end else spi_send(tbl[i].w, tbl[i].rd);
      repeat (10) @(negedge clk);
    end

    // SPI word lands while the host owns the RAM: held in skid, sent after the data word
    fork
      begin host_op(1, 8'h10, 8'h3C, 8'h00, 10, w); chk("skid_host_lat", w, 1); end
      begin
        repeat (2) @(negedge clk);
        spi_rx_valid = 1'b1; spi_rx_data = 10'h210;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        chk("skid_hold", ram_rx_valid, 0);
        @(negedge clk);
        chk("skid_fwd", {ram_rx_valid, ram_din}, {1'b1, 10'h210});
      end
    join
    repeat (10) @(negedge clk);
    spi_send(10'h300, 8'h3C);
    repeat (10) @(negedge clk);

    // host stalled by an SPI address lock until the data word
    spi_send(10'h020, 8'h00);
    fork
      begin host_op(0, 8'h20, 8'h00, 8'hFF, 60, w); chk("lock_stall_lat", w, 32); end
      begin repeat (30) @(negedge clk); spi_send(10'h1FF, 8'h00); end
    join
    repeat (10) @(negedge clk);

    // lock released by the timer
    spi_send(10'h020, 8'h00);
    host_op(0, 8'h20, 8'h00, 8'hFF, 100, w);
    chk("timeout_lat", w, LOCK_TIMEOUT + 2);
`ifdef SPI_ARB_STATUS_EN
    chk("lock_timeouts", lock_timeouts, 1);
`endif
    repeat (10) @(negedge clk);

    // same-cycle SPI and host: SPI first, its read data goes only to SPI
    fork
      begin host_op(0, 8'h55, 8'h00, 8'hA7, 40, w); chk("same_cycle_lat", w, 15); end
      begin spi_send(10'h2AA, 8'h00); repeat (10) @(negedge clk); spi_send(10'h300, 8'h00); end
    join
    repeat (10) @(negedge clk);

    // two SPI words while the skid is full: the older one survives
    fork
      begin host_op(1, 8'h81, 8'h11, 8'h00, 10, w); chk("ovf_host_lat", w, 1); end
      begin
        @(negedge clk);
        spi_rx_valid = 1'b1; spi_rx_data = 10'h2B0;
        @(negedge clk);
        spi_rx_data = 10'h2B1;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        chk("ovf_hold", ram_rx_valid, 0);
        @(negedge clk);
        chk("ovf_keep_old", {ram_rx_valid, ram_din}, {1'b1, 10'h2B0});
        ss_n = 1'b1;
        @(negedge clk);
        ss_n = 1'b0;
        chk("ovf_drop_new", ram_rx_valid, 0);
`ifdef SPI_ARB_STATUS_EN
        chk("err_overflow", err_overflow, 1);
`endif
      end
    join
    host_op(0, 8'h81, 8'h00, 8'h11, 10, w);
    chk("ssn_release_lat", w, 1);
    repeat (4) @(negedge clk);

    // reset while in H_DATA abandons the host read
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h55;
    @(negedge clk);
    chk("rst_gnt", host_gnt, 1);
    host_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", {spi_tx_valid, spi_tx_data, host_gnt, host_rvalid, host_rdata, ram_rx_valid, ram_din}, 0);
`ifdef SPI_ARB_STATUS_EN
    chk("rst_status", {err_overflow, lock_timeouts}, 0);
`endif
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_quiet", {ram_rx_valid, host_rvalid, host_gnt, spi_tx_valid}, 0);
    end

    // randomized concurrent traffic: SPI owns 0x00-0x7F, host owns 0x80-0xFF
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rand_on = 1'b1;
    fork
      for (int i = 0; i < 40; i++) begin
        logic [7:0] sa, sd;
        sa = 8'($urandom_range(0, 127));
        sd = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          spi_raw({2'b00, sa});
          spi_raw({2'b01, sd});
          ref_mem[sa] = sd;
        end else begin
          spi_raw({2'b10, sa});
          exp_q.push_back(ref_mem[sa]);
          spi_raw(10'h300);
        end
      end
      for (int i = 0; i < 40; i++) begin
        int hw;
        bit we;
        a = 8'($urandom_range(128, 255));
        d = 8'($urandom);
        we = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 6)) @(negedge clk);
        host_op(we, a, d, ref_mem[a], 40, hw);
        if (we) ref_mem[a] = d;
      end
    join
    repeat (20) @(negedge clk);
    rand_on = 1'b0;
    chk("spi_q_empty", exp_q.size(), 0);
    for (int i = 0; i < 256; i++) chk($sformatf("mem[%0h]", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
